// File: rtl/bc_pkg.sv
// Shared types and constants for the station-ID barcode decoder.
// The FSM state encoding, frame width and timeout scaling live here.
`timescale 1ns/1ps
package bc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_FALL,
    SAMPLE,
    WAIT_HIGH,
    DONE
  } bc_state_t;

  localparam int ID_BITS       = 8;
  localparam int TIMEOUT_SHIFT = 2;

  // Station IDs occupy the low six bits; a frame with either top bit set is corrupt.
  function automatic logic id_frame_ok(input logic [ID_BITS-1:0] id);
    return (id[ID_BITS-1 -: 2] == 2'b00);
  endfunction

endpackage

// File: rtl/barcode_reader_if.sv
// Barcode line, ID-consumption handshake and decoded ID between the
// barcode source / command-control side (master) and the decoder (slave).
`timescale 1ns/1ps
interface barcode_reader_if;
  import bc_pkg::*;

  logic               BC;
  logic               clr_ID_vld;
  logic [ID_BITS-1:0] ID;
  logic               ID_vld;
  logic               busy;

  modport master (
    output BC,
    output clr_ID_vld,
    input  ID,
    input  ID_vld,
    input  busy
  );

  modport slave (
    input  BC,
    input  clr_ID_vld,
    output ID,
    output ID_vld,
    output busy
  );

endinterface

// File: rtl/bc_sync_edge.sv
// Two-flop synchroniser plus history flop for an idle-high serial line,
// producing the synchronised level and single-cycle rise/fall strobes.
`timescale 1ns/1ps
module bc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic cur,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic hist_p2;

  // Reset to the idle-high level so leaving reset never looks like a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      hist_p2 <= 1'b1;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
    end
  end

  assign cur  = sync_p1;
  assign fall = hist_p2 & ~sync_p1;
  assign rise = ~hist_p2 & sync_p1;

endmodule

// File: rtl/barcode_reader.sv
// Self-calibrating station-ID barcode decoder: the start-bit low width sets
// the sample point for each of the eight MSB-first data bits of the frame.
`timescale 1ns/1ps
module barcode_reader
  import bc_pkg::*;
#(
  parameter int CNT_W    = 22,
  parameter int MIN_HALF = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  barcode_reader_if.slave  bc_if
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_HALF_C = CNT_W'(MIN_HALF);
  localparam logic [3:0]       BIT_ONE    = 4'd1;
  localparam logic [3:0]       LAST_BIT   = 4'(ID_BITS - 1);

  logic                          cur;
  logic                          rise;
  logic                          fall;

  bc_state_t                     state;
  logic [CNT_W-1:0]              cnt;
  logic [CNT_W-1:0]              half;
  logic [ID_BITS-1:0]            shift;
  logic [3:0]                    bitcnt;
  logic [ID_BITS-1:0]            id_q;
  logic                          id_vld_q;

  logic [CNT_W+TIMEOUT_SHIFT-1:0] timeout;
  logic [CNT_W+TIMEOUT_SHIFT-1:0] cnt_ext;
  logic                           timed_out;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_ONE);
  endfunction

  bc_sync_edge u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bc_if.BC),
    .cur   (cur),
    .rise  (rise),
    .fall  (fall)
  );

  // Timeout is computed wide so a large half-period cannot wrap; a pinned
  // counter also counts as expired so a huge timeout can never hang the FSM.
  assign timeout   = {{TIMEOUT_SHIFT{1'b0}}, half} << TIMEOUT_SHIFT;
  assign cnt_ext   = {{TIMEOUT_SHIFT{1'b0}}, cnt};
  assign timed_out = (cnt_ext >= timeout) || (&cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      half     <= '0;
      shift    <= '0;
      bitcnt   <= '0;
      id_q     <= '0;
      id_vld_q <= 1'b0;
    end else begin
      // A set in DONE below overrides this clear when both land together.
      if (bc_if.clr_ID_vld) id_vld_q <= 1'b0;

      case (state)
        IDLE: begin
          if (fall) begin
            cnt    <= CNT_ONE;
            bitcnt <= '0;
            shift  <= '0;
            state  <= START;
          end
        end

        START: begin
          if (rise) begin
            half  <= cnt;
            cnt   <= '0;
            state <= (cnt < MIN_HALF_C) ? IDLE : WAIT_FALL;
          end else if (&cnt) begin
            state <= IDLE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        WAIT_FALL: begin
          if (fall) begin
            cnt   <= CNT_ONE;
            state <= SAMPLE;
          end else if (timed_out) begin
            state <= IDLE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        // Early rising edges are ignored; only the line level at cnt==half counts.
        SAMPLE: begin
          cnt <= sat_inc(cnt);
          if (cnt == half) begin
            shift  <= {shift[ID_BITS-2:0], cur};
            bitcnt <= bitcnt + BIT_ONE;
            state  <= (bitcnt == LAST_BIT) ? DONE : WAIT_HIGH;
          end
        end

        WAIT_HIGH: begin
          if (cur) begin
            cnt   <= '0;
            state <= WAIT_FALL;
          end else if (timed_out) begin
            state <= IDLE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        DONE: begin
          if (id_frame_ok(shift)) begin
            id_q     <= shift;
            id_vld_q <= 1'b1;
          end
          bitcnt <= '0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bc_if.ID     = id_q;
  assign bc_if.ID_vld = id_vld_q;
  assign bc_if.busy   = (state != IDLE);

endmodule
